// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
// Defining BOOTH_SIGN_SEL_EN adds one extra step so that operands can be zero-extended.
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

`ifdef BOOTH_SIGN_SEL_EN
    localparam int EXTRA_STEPS = 1;
`else
    localparam int EXTRA_STEPS = 0;
`endif

    // Internal operand width E, which is also the number of Booth steps.
    function automatic int steps(input int width);
        return width + EXTRA_STEPS;
    endfunction

    function automatic int count_width(input int e);
        return $clog2(e + 1);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/sub of M into A, then arithmetic
// right shift of {A,Q,F}.
module booth_step #(
    parameter int E = 4
) (
    input  logic [E:0]   a_in,
    input  logic [E:0]   m,
    input  logic [E-1:0] q_in,
    input  logic         f_in,
    output logic [E:0]   a_out,
    output logic [E-1:0] q_out,
    output logic         f_out
);

    logic [E:0] sum;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sum = a_in;
        case ({q_in[0], f_in})
            2'b01:   sum = a_in + m;
            2'b10:   sum = a_in - m;
            default: sum = a_in;
        endcase
    end

    assign a_out = {sum[E], sum[E:1]};
    assign q_out = {sum[0], q_in[E-1:1]};
    assign f_out = q_in[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with a start/busy/done handshake.
// Defining BOOTH_SIGN_SEL_EN adds the is_signed input, which selects a signed or unsigned multiply.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef BOOTH_SIGN_SEL_EN
    input  logic               is_signed,
`endif
    output logic [2*WIDTH-1:0] prod,
    output logic               busy,
    output logic               done
);

    localparam int E  = steps(WIDTH);
    localparam int CW = count_width(E);

    state_t          state_q, state_d;
    logic [E:0]      m_r, a_r;
    logic [E-1:0]    q_r;
    logic            f_r;
    logic [CW-1:0]   cnt;

    logic [E:0]      a_nx;
    logic [E-1:0]    q_nx;
    logic            f_nx;
    logic            sign_a;
    logic [E-1:0]    q_load;

`ifdef BOOTH_SIGN_SEL_EN
    assign sign_a = is_signed & a[WIDTH-1];
    assign q_load = {is_signed & b[WIDTH-1], b};
`else
    assign sign_a = a[WIDTH-1];
    assign q_load = b;
`endif

    booth_step #(.E(E)) u_step (
        .a_in  (a_r),
        .m     (m_r),
        .q_in  (q_r),
        .f_in  (f_r),
        .a_out (a_nx),
        .q_out (q_nx),
        .f_out (f_nx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt == CW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_r  <= '0;
            a_r  <= '0;
            q_r  <= '0;
            f_r  <= 1'b0;
            cnt  <= '0;
            prod <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // The guard bit on M keeps A-M in range for the most negative operand.
                        m_r <= {{(E + 1 - WIDTH){sign_a}}, a};
                        a_r <= '0;
                        q_r <= q_load;
                        f_r <= 1'b0;
                        cnt <= CW'(E);
                    end
                end
                RUN: begin
                    a_r <= a_nx;
                    q_r <= q_nx;
                    f_r <= f_nx;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        prod <= {a_nx[2*WIDTH-E-1:0], q_nx};
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench: WIDTH=4 directed vectors and handshake corners,
// then a WIDTH=8 randomized sweep against an arithmetic reference model.
module tb_booth_mult_seq;

`ifdef BOOTH_SIGN_SEL_EN
    localparam int EXT = 1;
`else
    localparam int EXT = 0;
`endif
    localparam int E4 = 4 + EXT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s4 = 1'b0, s8 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       sg4 = 1'b1, sg8 = 1'b1;
    logic [7:0] p4;
    logic [15:0] p8;
    logic       busy4, done4, busy8, done8;

    int n_cmp = 0;
    int n_fail = 0;
    int done8_cnt = 0;
    int start8_cnt = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4),
`ifdef BOOTH_SIGN_SEL_EN
        .is_signed(sg4),
`endif
        .prod(p4), .busy(busy4), .done(done4)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
`ifdef BOOTH_SIGN_SEL_EN
        .is_signed(sg8),
`endif
        .prod(p8), .busy(busy8), .done(done8)
    );

    always @(posedge clk) if (done8) done8_cnt <= done8_cnt + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint model(input int w, input logic [7:0] a, input logic [7:0] b,
                                     input logic sgn);
        longint x, y;
        x = longint'(a) & ((longint'(1) << w) - 1);
        y = longint'(b) & ((longint'(1) << w) - 1);
        if (sgn && a[w-1]) x = x - (longint'(1) << w);
        if (sgn && b[w-1]) y = y - (longint'(1) << w);
        return (x * y) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Starts one WIDTH=4 multiply and returns at the negedge where done is seen.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sgn,
                        output int lat, output int busy_n);
        @(negedge clk);
        a4 = a; b4 = b; sg4 = sgn; s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        lat = 1; busy_n = 0;
        while (!done4 && lat < 40) begin
            if (busy4) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sgn);
        int k;
        @(negedge clk);
        a8 = a; b8 = b; sg8 = sgn; s8 = 1'b1;
        start8_cnt++;
        @(negedge clk);
        s8 = 1'b0;
        k = 1;
        while (!done8 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("w8_latency", k, 8 + EXT + 1);
        check($sformatf("w8_prod a=%0h b=%0h s=%0b", a, b, sgn), p8, model(8, a, b, sgn));
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sgn;
        logic [7:0] exp;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int lat, busy_n, n;
        logic [7:0] corners[4];

        vecs.push_back('{4'h3, 4'hE, 1'b1, 8'hFA});
        vecs.push_back('{4'h8, 4'h8, 1'b1, 8'h40});
        vecs.push_back('{4'h8, 4'h7, 1'b1, 8'hC8});
        vecs.push_back('{4'h0, 4'hB, 1'b1, 8'h00});
        vecs.push_back('{4'h7, 4'h7, 1'b1, 8'h31});
`ifdef BOOTH_SIGN_SEL_EN
        vecs.push_back('{4'hF, 4'hF, 1'b0, 8'hE1});
        vecs.push_back('{4'hF, 4'hF, 1'b1, 8'h01});
        vecs.push_back('{4'h8, 4'h8, 1'b0, 8'h40});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_prod4", p4, 0);
        check("rst_busy4", busy4, 0);
        check("rst_done4", done4, 0);
        check("rst_prod8", p8, 0);
        check("rst_busy8", busy8, 0);

        // Directed vectors
        foreach (vecs[i]) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].sgn, lat, busy_n);
            check($sformatf("vec%0d_prod", i), p4, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, E4 + 1);
            check($sformatf("vec%0d_busy_cycles", i), busy_n, E4);
            check($sformatf("vec%0d_busy_at_done", i), busy4, 0);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), done4, 0);
            check($sformatf("vec%0d_prod_hold", i), p4, vecs[i].exp);
        end

        // Back-to-back start in the done cycle, with a start pulse mid-run
        run4(4'h3, 4'hE, 1'b1, lat, busy_n);
        check("b2b_first", p4, 8'hFA);
        a4 = 4'h5; b4 = 4'h5; s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        n = 1;
        while (!done4 && n < 40) begin
            if (n == 2) begin s4 = 1'b1; a4 = 4'h1; b4 = 4'h1; end
            if (n == 3) s4 = 1'b0;
            @(negedge clk);
            n++;
        end
        check("b2b_spacing", n, E4 + 1);
        check("b2b_prod", p4, 8'h19);
        repeat (3) begin
            @(negedge clk);
            check("b2b_no_relaunch", {busy4, done4}, 2'b00);
        end

        // Reset mid-operation, then a fresh multiply
        @(negedge clk);
        a4 = 4'h5; b4 = 4'h3; s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy4, 0);
        check("abort_prod", p4, 0);
        check("abort_done", done4, 0);
        n = 0;
        repeat (E4 + 2) begin
            @(negedge clk);
            if (done4) n++;
        end
        check("abort_no_done", n, 0);
        run4(4'h5, 4'h3, 1'b1, lat, busy_n);
        check("after_abort_prod", p4, 8'h0F);

        // Reset and start together: reset wins
        @(negedge clk);
        a4 = 4'h2; b4 = 4'h2; s4 = 1'b1; rst = 1'b1;
        @(negedge clk);
        s4 = 1'b0; rst = 1'b0;
        check("rst_start_busy", busy4, 0);
        check("rst_start_prod", p4, 0);

        // WIDTH=8 sweep: corner pairs then random operands
        corners[0] = 8'h80; corners[1] = 8'h7F; corners[2] = 8'h00; corners[3] = 8'hFF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                run8(corners[i], corners[j], 1'b1);
        for (int i = 0; i < 40; i++) begin
            logic sgn;
            sgn = 1'b1;
`ifdef BOOTH_SIGN_SEL_EN
            sgn = 1'($urandom_range(0, 1));
`endif
            run8(8'($urandom), 8'($urandom), sgn);
        end
        @(negedge clk);
        check("w8_done_count", done8_cnt, start8_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
